text_fetch_ctrl: RTL and testbench

- Sequences the text-mode character pipeline: text RAM, then the font ROM bank, then the pixel shifter.
- Uses the sync generator's HCOUNT/VCOUNT to prefetch each 10x16 character cell one cell ahead.
- Drives the shared CHAR/ROW bus into the FontRom bank and serialises the returned 10-bit row to one pixel per CLK.
- Sits between the VGA timing generator and the DAC/output stage.

---
 rtl/text_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_text_fetch_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/text_fetch_ctrl.sv
// Text-mode fetch sequencer: text RAM -> font ROM -> pixel shifter, one cell ahead of display.
// Latency: pixel for HCOUNT=x appears on PIXEL_OUT while HCOUNT=x+1; no backpressure (free-running).
// Optional underline cursor enabled by defining CURSOR_EN.
`timescale 1ns/1ps
module text_fetch_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int CELL_W   = 10,
  parameter int COLS     = 64,
  parameter int ADDR_W   = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        HCOUNT,
  input  logic [9:0]        VCOUNT,
  output logic [ADDR_W-1:0] TXT_ADDR,
  input  logic [7:0]        TXT_DATA,
  output logic [7:0]        CHAR_OUT,
  output logic [3:0]        ROW_OUT,
  input  logic [CELL_W-1:0] FONT_DATA,
  output logic              PIXEL_OUT,
`ifdef CURSOR_EN
  input  logic [5:0]        CUR_COL,
  input  logic [4:0]        CUR_ROW,
`endif
  output logic              ACTIVE_OUT
);

  localparam int PW = $clog2(CELL_W);
  localparam int CW = $clog2(COLS);
  localparam logic [9:0]        H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0]        H_START  = 10'(H_TOTAL - CELL_W);
  localparam logic [9:0]        V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0]        V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [PW-1:0]     P_LAST   = PW'(CELL_W - 1);
  localparam logic [CW-1:0]     LAST_COL = CW'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_L   = ADDR_W'(COLS);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     p_q, p_n;
  logic [CW-1:0]     col, col_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        char_n;
  logic [3:0]        row_n;
  logic [CELL_W-1:0] row_buf, row_buf_n;
  logic [CELL_W-1:0] shreg, shreg_n;
  logic [9:0]        tl;
  logic              hstart, tl_ok, fetching, act, pix_n;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [5:0] trow, input logic [CW-1:0] c);
    return ADDR_W'(trow) * COLS_L + ADDR_W'(c);
  endfunction

  // Past the visible region the fetch works on the following line.
  always_comb begin
    tl = VCOUNT;
    if (HCOUNT >= H_ACT_L)
      tl = (VCOUNT == V_LAST_L) ? 10'd0 : VCOUNT + 10'd1;
  end

  assign hstart   = (HCOUNT == H_START);
  assign tl_ok    = (tl < V_ACT_L);
  assign fetching = (state == PREFETCH) || (state == RUN);
  assign act      = (HCOUNT < H_ACT_L) && (VCOUNT < V_ACT_L);

  always_comb begin
    state_n   = state;
    p_n       = p_q;
    col_n     = col;
    addr_n    = TXT_ADDR;
    char_n    = CHAR_OUT;
    row_n     = ROW_OUT;
    row_buf_n = row_buf;
    shreg_n   = shreg << 1;
    if (hstart) begin
      col_n = '0;
      if (tl_ok) begin
        state_n = PREFETCH;
        p_n     = PW'(1);
        addr_n  = addr_of(tl[9:4], '0);
      end else begin
        state_n = IDLE;
        p_n     = '0;
      end
    end else begin
      if (state == IDLE) p_n = '0;
      else               p_n = (p_q == P_LAST) ? '0 : p_q + 1'b1;
      if (fetching) begin
        if (state == RUN && p_q == '0) begin
          col_n  = col + 1'b1;
          addr_n = addr_of(tl[9:4], col + 1'b1);
        end
        if (p_q == PW'(2)) begin
          char_n = TXT_DATA;
          row_n  = tl[3:0];
        end
        if (p_q == PW'(3)) row_buf_n = FONT_DATA;
        // Cell boundary: hand the fetched row to the shifter.
        if (p_q == P_LAST) begin
          shreg_n = row_buf;
          state_n = (state == RUN && col == LAST_COL) ? DRAIN : RUN;
        end
      end else if (state == DRAIN && HCOUNT == H_ACT_L) begin
        state_n = IDLE;
      end
    end
  end

`ifdef CURSOR_EN
  logic [4:0]    frame_cnt;
  logic [CW-1:0] disp_col;
  logic          cur_hit;

  assign cur_hit = frame_cnt[4] && (state == RUN || state == DRAIN) &&
                   (disp_col == CW'(CUR_COL)) && (VCOUNT[9:4] == {1'b0, CUR_ROW}) &&
                   (VCOUNT[3:1] == 3'b111);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      frame_cnt <= '0;
      disp_col  <= '0;
    end else begin
      if (VCOUNT == V_ACT_L && HCOUNT == 10'd0) frame_cnt <= frame_cnt + 1'b1;
      // Tracks the column currently in the shifter.
      if (!hstart && fetching && p_q == P_LAST)
        disp_col <= (state == PREFETCH) ? '0 : disp_col + 1'b1;
    end
  end
`endif

  always_comb begin
    pix_n = act & shreg[CELL_W-1];
`ifdef CURSOR_EN
    if (act && cur_hit) pix_n = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      p_q        <= '0;
      col        <= '0;
      TXT_ADDR   <= '0;
      CHAR_OUT   <= 8'h20;
      ROW_OUT    <= '0;
      row_buf    <= '0;
      shreg      <= '0;
      PIXEL_OUT  <= 1'b0;
      ACTIVE_OUT <= 1'b0;
    end else begin
      state      <= state_n;
      p_q        <= p_n;
      col        <= col_n;
      TXT_ADDR   <= addr_n;
      CHAR_OUT   <= char_n;
      ROW_OUT    <= row_n;
      row_buf    <= row_buf_n;
      shreg      <= shreg_n;
      PIXEL_OUT  <= pix_n;
      ACTIVE_OUT <= act;
    end
  end

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Directed bench for text_fetch_ctrl with a 1-cycle text RAM and a negedge font ROM model.
`timescale 1ns/1ps
module tb_text_fetch_ctrl;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  HCOUNT, VCOUNT;
  logic [10:0] TXT_ADDR;
  logic [7:0]  TXT_DATA;
  logic [7:0]  CHAR_OUT;
  logic [3:0]  ROW_OUT;
  logic [9:0]  FONT_DATA;
  logic        PIXEL_OUT, ACTIVE_OUT;
`ifdef CURSOR_EN
  logic [5:0]  CUR_COL = 6'd0;
  logic [4:0]  CUR_ROW = 5'd0;
`endif

  int checks = 0;
  int errors = 0;
  int ones;
  logic [7:0] ram [0:2047];

  function automatic logic [9:0] font(input logic [7:0] c, input logic [3:0] r);
    return {c, r[1:0]} ^ 10'h2A5;
  endfunction

  text_fetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .HCOUNT(HCOUNT), .VCOUNT(VCOUNT),
    .TXT_ADDR(TXT_ADDR), .TXT_DATA(TXT_DATA), .CHAR_OUT(CHAR_OUT), .ROW_OUT(ROW_OUT),
    .FONT_DATA(FONT_DATA), .PIXEL_OUT(PIXEL_OUT),
`ifdef CURSOR_EN
    .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW),
`endif
    .ACTIVE_OUT(ACTIVE_OUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) TXT_DATA <= ram[TXT_ADDR];
  always @(negedge CLK) FONT_DATA <= font(CHAR_OUT, ROW_OUT);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (HCOUNT == 10'd799) begin
      HCOUNT = 10'd0;
      VCOUNT = (VCOUNT == 10'd524) ? 10'd0 : VCOUNT + 10'd1;
    end else begin
      HCOUNT = HCOUNT + 10'd1;
    end
  endtask

  task automatic run_to(input int v, input int h);
    int n = 0;
    while (!(VCOUNT == 10'(v) && HCOUNT == 10'(h)) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $error("FAIL run_to timeout: observed v=%0d h=%0d expected v=%0d h=%0d", VCOUNT, HCOUNT, v, h);
    end
  endtask

  // Starting with HCOUNT at the cell's first pixel, check its ten pixels MSB first.
  task automatic cell_check(input string tag, input logic [9:0] row);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("%s_px%0d", tag, i), PIXEL_OUT, row[9-i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[0] = 8'h48;
    RESET = 1'b0; HCOUNT = 10'd0; VCOUNT = 10'd0;
    repeat (3) step();
    chk("rst_addr", TXT_ADDR, 0);
    chk("rst_char", CHAR_OUT, 8'h20);
    chk("rst_row", ROW_OUT, 0);
    chk("rst_pix", PIXEL_OUT, 0);
    chk("rst_act", ACTIVE_OUT, 0);

    // Line 1 prefetched at the end of line 0.
    RESET = 1'b1; HCOUNT = 10'd780; VCOUNT = 10'd0;
    run_to(0, 792);
    chk("l1_char_early", CHAR_OUT, 8'h20);
    run_to(0, 793);
    chk("l1_char", CHAR_OUT, 8'h48);
    chk("l1_row", ROW_OUT, 1);
    run_to(1, 0);
    chk("l1_blank_pix", PIXEL_OUT, 0);
    chk("l1_act_pre", ACTIVE_OUT, 0);
    cell_check("l1c0", 10'h384);
    chk("l1_act", ACTIVE_OUT, 1);
    cell_check("l1c1", font(8'h5B, 4'd1));

    // Reset held for 3 clocks mid-line.
    run_to(1, 200);
    RESET = 1'b0;
    repeat (3) step();
    chk("mid_rst_addr", TXT_ADDR, 0);
    chk("mid_rst_char", CHAR_OUT, 8'h20);
    chk("mid_rst_row", ROW_OUT, 0);
    chk("mid_rst_pix", PIXEL_OUT, 0);
    chk("mid_rst_act", ACTIVE_OUT, 0);
    RESET = 1'b1;
    ones = 0;
    for (int n = 0; n < 1000 && !(VCOUNT == 10'd2 && HCOUNT == 10'd0); n++) begin
      step();
      ones += int'(PIXEL_OUT);
    end
    chk("mid_rst_quiet", ones, 0);
    cell_check("l2c0", font(8'h48, 4'd2));

    // Last column of text row 1.
    HCOUNT = 10'd785; VCOUNT = 10'd16;
    run_to(17, 621);
    chk("l17_addr63", TXT_ADDR, 127);
    run_to(17, 630);
    cell_check("l17c63", font(8'h25, 4'd1));
    chk("l17_act_last", ACTIVE_OUT, 1);
    step();
    chk("l17_blank_pix", PIXEL_OUT, 0);
    chk("l17_blank_act", ACTIVE_OUT, 0);
    run_to(17, 700);
    chk("l17_drain_addr", TXT_ADDR, 127);

    // No prefetch past the last visible line.
    HCOUNT = 10'd785; VCOUNT = 10'd479;
    run_to(479, 799);
    chk("l479_addr", TXT_ADDR, 127);
    chk("l479_char", CHAR_OUT, 8'h25);
    ones = 0;
    for (int n = 0; n < 800; n++) begin
      step();
      ones += int'(PIXEL_OUT) + int'(ACTIVE_OUT);
    end
    HCOUNT = 10'd0; VCOUNT = 10'd523;
    for (int n = 0; n < 4000 && !(VCOUNT == 10'd524 && HCOUNT == 10'd789); n++) begin
      step();
      ones += int'(PIXEL_OUT) + int'(ACTIVE_OUT);
    end
    chk("vblank_quiet", ones, 0);
    chk("vblank_addr", TXT_ADDR, 127);

    // Vertical wrap: line 524 prefetches line 0.
    run_to(524, 791);
    chk("wrap_addr", TXT_ADDR, 0);
    run_to(524, 793);
    chk("wrap_char", CHAR_OUT, 8'h48);
    chk("wrap_row", ROW_OUT, 0);
    run_to(0, 0);
    cell_check("l0c0", 10'h385);
    cell_check("l0c1", font(8'h5B, 4'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
